// File: rtl/cdb_wb_buffer_pkg.sv
// Shared CDB constants for the write-back buffer: result/label widths and the
// "value already in register file" label.
package cdb_wb_buffer_pkg;
    localparam int CDB_DATA_W  = 32;
    localparam int CDB_LABEL_W = 4;
    localparam int NO_LABEL    = 0;
endpackage

// File: rtl/cdb_wb_buffer_if.sv
// Handshake bundle between a functional unit, its write-back buffer and the CDB.
// The functional unit and CDBHelper together form the master side; the buffer is the slave.
interface cdb_wb_buffer_if
    import cdb_wb_buffer_pkg::*;
#(
    parameter int DATA_W  = CDB_DATA_W,
    parameter int LABEL_W = CDB_LABEL_W
);
    logic               WEN;
    logic [DATA_W-1:0]  dataIn;
    logic [LABEL_W-1:0] labelIn;
    logic               isFull;
    logic               require;
    logic               requireAC;
    logic [DATA_W-1:0]  dataOut;
    logic [LABEL_W-1:0] labelOut;

    modport master (
        output WEN, dataIn, labelIn, requireAC,
        input  isFull, require, dataOut, labelOut
    );

    modport slave (
        input  WEN, dataIn, labelIn, requireAC,
        output isFull, require, dataOut, labelOut
    );
endinterface

// File: rtl/cdb_wb_buffer_wb_fifo_mem.sv
// Entry storage for the write-back buffer: DEPTH x WIDTH registers,
// synchronous write, asynchronous read.
module wb_fifo_mem #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 36
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);
    logic [DEPTH-1:0][WIDTH-1:0] mem;

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/cdb_wb_buffer.sv
// Result write-back FIFO between one functional unit and the CDB arbiter.
// Optional CDB_WB_BYPASS_EN: an empty buffer forwards a push straight to the CDB outputs.
module cdb_wb_buffer
    import cdb_wb_buffer_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int DATA_W  = CDB_DATA_W,
    parameter int LABEL_W = CDB_LABEL_W
) (
    input  logic                       clk,
    input  logic                       RST,
    cdb_wb_buffer_if.slave             bus,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int ENT_W = DATA_W + LABEL_W;

    logic [PTR_W-1:0] rdPtr, wrPtr;
    logic [ENT_W-1:0] headEntry;
    logic             validPush, storedReq, doPush, doPop;
    logic             bypassHit, bypassTake;

    assign validPush  = bus.WEN && (bus.labelIn != LABEL_W'(NO_LABEL));
    assign storedReq  = (count != '0);
    assign bus.isFull = (count == CNT_W'(DEPTH));

`ifdef CDB_WB_BYPASS_EN
    assign bypassHit  = validPush && !storedReq;
    // A bypassed result granted in the same cycle has already been broadcast.
    assign bypassTake = bypassHit && bus.requireAC;
`else
    assign bypassHit  = 1'b0;
    assign bypassTake = 1'b0;
`endif

    assign doPop  = storedReq && bus.requireAC;
    assign doPush = validPush && !bus.isFull && !bypassTake;

    assign bus.require  = storedReq || bypassHit;
    assign bus.dataOut  = storedReq ? headEntry[ENT_W-1:LABEL_W] :
                          bypassHit ? bus.dataIn : '0;
    assign bus.labelOut = storedReq ? headEntry[LABEL_W-1:0] :
                          bypassHit ? bus.labelIn : '0;

    always_ff @(posedge clk) begin
        if (RST) begin
            rdPtr    <= '0;
            wrPtr    <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (doPush) wrPtr <= wrPtr + PTR_W'(1);
            if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
            if (doPush && !doPop)      count <= count + CNT_W'(1);
            else if (!doPush && doPop) count <= count - CNT_W'(1);
            // A full buffer refuses even when a pop frees a slot this cycle.
            if (validPush && bus.isFull) overflow <= 1'b1;
        end
    end

    wb_fifo_mem #(.DEPTH(DEPTH), .WIDTH(ENT_W)) uMem (
        .clk   (clk),
        .we    (doPush),
        .waddr (wrPtr),
        .wdata ({bus.dataIn, bus.labelIn}),
        .raddr (rdPtr),
        .rdata (headEntry)
    );
endmodule

// File: tb/tb_cdb_wb_buffer.sv
// Self-checking bench for cdb_wb_buffer against a queue-based model of the buffer.
module tb_cdb_wb_buffer;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       RST;
    logic [2:0] count;
    logic       overflow;
    int         tests = 0;
    int         fails = 0;

    logic [35:0] mq[$];
    logic        movf = 1'b0;

    cdb_wb_buffer_if #(.DATA_W(32), .LABEL_W(4)) bus ();

    cdb_wb_buffer #(.DEPTH(DEPTH), .DATA_W(32), .LABEL_W(4)) dut (
        .clk      (clk),
        .RST      (RST),
        .bus      (bus),
        .count    (count),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs from a negedge, advance the model on the edge,
    // then return at the next negedge with inputs idle.
    task automatic step(input logic rst, input logic wen, input logic [31:0] d,
                        input logic [3:0] l, input logic ac);
        int   sz;
        logic byp;
        RST = rst; bus.WEN = wen; bus.dataIn = d; bus.labelIn = l; bus.requireAC = ac;
        @(posedge clk);
        sz  = mq.size();
        byp = 1'b0;
        if (rst) begin
            mq.delete();
            movf = 1'b0;
        end else begin
`ifdef CDB_WB_BYPASS_EN
            byp = (sz == 0) && wen && (l != 0) && ac;
`endif
            if (sz != 0 && ac) void'(mq.pop_front());
            if (wen && l != 0 && !byp) begin
                if (sz == DEPTH) movf = 1'b1;
                else mq.push_back({d, l});
            end
        end
        #1;
        RST = 1'b0; bus.WEN = 1'b0; bus.requireAC = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 0, 1'($urandom_range(0, 1)));
            tests++;
            if (bus.require !== 1'b0 || count !== 3'd0 || bus.dataOut !== 32'd0 || overflow !== 1'b0) begin
                fails++;
                $display("FAIL reset_idle cyc%0d: require=%b count=%0d dataOut=%h ovf=%b, want 0/0/0/0",
                         i, bus.require, count, bus.dataOut, overflow);
            end
        end
    endtask

    task automatic test_single();
        step(0, 1, 32'h5, 4'd3, 0);
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (bus.require !== 1'b1 || bus.labelOut !== 4'd3 || bus.dataOut !== 32'h5 || count !== 3'd1) begin
                fails++;
                $display("FAIL single_hold cyc%0d: require=%b label=%0d data=%h count=%0d, want 1/3/5/1",
                         i, bus.require, bus.labelOut, bus.dataOut, count);
            end
            step(0, 0, 0, 0, 0);
        end
        step(0, 0, 0, 0, 1);
        tests++;
        if (count !== 3'd0 || bus.require !== 1'b0 || bus.labelOut !== 4'd0) begin
            fails++;
            $display("FAIL single_grant: count=%0d require=%b label=%0d, want 0/0/0",
                     count, bus.require, bus.labelOut);
        end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 5; i++) begin
            tests++;
            if (bus.isFull !== (i == 5)) begin
                fails++;
                $display("FAIL fill_isFull before push%0d: isFull=%b want %b", i, bus.isFull, (i == 5));
            end
            step(0, 1, $urandom, 4'(i), 0);
        end
        tests++;
        if (overflow !== 1'b1 || count !== 3'd4 || bus.isFull !== 1'b1) begin
            fails++;
            $display("FAIL fill_overflow: ovf=%b count=%0d isFull=%b, want 1/4/1", overflow, count, bus.isFull);
        end
        for (int i = 1; i <= 4; i++) begin
            tests++;
            if (bus.labelOut !== 4'(i) || bus.dataOut !== mq[0][35:4]) begin
                fails++;
                $display("FAIL drain_order %0d: label=%0d data=%h, want %0d/%h",
                         i, bus.labelOut, bus.dataOut, i, mq[0][35:4]);
            end
            step(0, 0, 0, 0, 1);
            tests++;
            if (bus.isFull !== 1'b0) begin
                fails++;
                $display("FAIL drain_isFull %0d: isFull=%b want 0", i, bus.isFull);
            end
        end
        tests++;
        if (count !== 3'd0 || bus.require !== 1'b0 || overflow !== 1'b1) begin
            fails++;
            $display("FAIL drain_empty: count=%0d require=%b ovf=%b, want 0/0/1", count, bus.require, overflow);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] prevLabel;
        prevLabel = 4'($urandom_range(1, 15));
        step(0, 1, $urandom, prevLabel, 0);
        for (int i = 0; i < 20; i++) begin
            logic [3:0] nl;
            nl = 4'($urandom_range(1, 15));
            tests++;
            if (bus.labelOut !== prevLabel || bus.labelOut !== mq[0][3:0]) begin
                fails++;
                $display("FAIL b2b_label cyc%0d: label=%0d want %0d", i, bus.labelOut, prevLabel);
            end
            step(0, 1, $urandom, nl, 1);
            prevLabel = nl;
            tests++;
            if (count !== 3'd1 || bus.require !== 1'b1) begin
                fails++;
                $display("FAIL b2b_count cyc%0d: count=%0d require=%b, want 1/1", i, count, bus.require);
            end
        end
        step(0, 0, 0, 0, 1);
    endtask

    task automatic test_label0();
        step(1, 0, 0, 0, 0);
        step(0, 1, 32'h1234, 4'd0, 0);
        tests++;
        if (count !== 3'd0 || overflow !== 1'b0 || bus.require !== 1'b0) begin
            fails++;
            $display("FAIL label0_empty: count=%0d ovf=%b require=%b, want 0/0/0", count, overflow, bus.require);
        end
        step(0, 1, 32'h77, 4'd9, 0);
        step(0, 1, 32'h88, 4'd0, 0);
        tests++;
        if (count !== 3'd1 || overflow !== 1'b0 || bus.labelOut !== 4'd9) begin
            fails++;
            $display("FAIL label0_held: count=%0d ovf=%b label=%0d, want 1/0/9", count, overflow, bus.labelOut);
        end
    endtask

    task automatic test_reset_mid();
        step(0, 1, $urandom, 4'd2, 0);
        step(0, 1, $urandom, 4'd4, 0);
        tests++;
        if (count !== 3'd3) begin
            fails++;
            $display("FAIL rstmid_setup: count=%0d want 3", count);
        end
        step(1, 1, $urandom, 4'd6, 1);
        tests++;
        if (count !== 3'd0 || bus.require !== 1'b0 || bus.isFull !== 1'b0 || bus.dataOut !== 32'd0 ||
            bus.labelOut !== 4'd0 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL rstmid: count=%0d req=%b full=%b data=%h label=%0d ovf=%b, want all 0",
                     count, bus.require, bus.isFull, bus.dataOut, bus.labelOut, overflow);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            int sz;
            step(0, 1'($urandom_range(0, 3) != 0), $urandom, 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 2) == 0));
            sz = mq.size();
            tests++;
            if (count !== 3'(sz) || bus.require !== (sz != 0) || bus.isFull !== (sz == DEPTH) ||
                overflow !== movf ||
                bus.labelOut !== ((sz != 0) ? mq[0][3:0] : 4'd0) ||
                bus.dataOut !== ((sz != 0) ? mq[0][35:4] : 32'd0)) begin
                fails++;
                $display("FAIL random cyc%0d: count=%0d/%0d req=%b full=%b ovf=%b/%b label=%0d/%0d data=%h/%h",
                         i, count, sz, bus.require, bus.isFull, overflow, movf, bus.labelOut,
                         (sz != 0) ? mq[0][3:0] : 4'd0, bus.dataOut, (sz != 0) ? mq[0][35:4] : 32'd0);
            end
        end
    endtask

`ifdef CDB_WB_BYPASS_EN
    task automatic test_bypass();
        step(1, 0, 0, 0, 0);
        bus.WEN = 1'b1; bus.dataIn = 32'hDEAD_BEEF; bus.labelIn = 4'd7; bus.requireAC = 1'b1;
        #1;
        tests++;
        if (bus.require !== 1'b1 || bus.labelOut !== 4'd7 || bus.dataOut !== 32'hDEAD_BEEF) begin
            fails++;
            $display("FAIL bypass_same_cycle: req=%b label=%0d data=%h, want 1/7/deadbeef",
                     bus.require, bus.labelOut, bus.dataOut);
        end
        step(0, 1, 32'hDEAD_BEEF, 4'd7, 1);
        tests++;
        if (count !== 3'd0 || bus.require !== 1'b0) begin
            fails++;
            $display("FAIL bypass_consumed: count=%0d req=%b, want 0/0", count, bus.require);
        end
    endtask
`endif

    initial begin
        RST = 1'b1; bus.WEN = 1'b0; bus.dataIn = '0; bus.labelIn = '0; bus.requireAC = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_fill();
        test_back_to_back();
        test_label0();
        test_reset_mid();
        test_random();
`ifdef CDB_WB_BYPASS_EN
        test_bypass();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/cdb_wb_buffer.md
# cdb_wb_buffer

Result write-back buffer sitting between one functional unit (pmfALU, mfALU, Memory) and the common data bus. It captures each finished result with its reservation-station label, raises `require` toward CDBHelper, and holds the head entry on `dataOut`/`labelOut` until the arbiter returns `requireAC`. Functional units can then complete while the CDB is granted elsewhere instead of stalling in their state machines.

## Interface
- `DEPTH`, 4, number of buffered results; power of two, at least 2.
- `DATA_W`, 32, result width.
- `LABEL_W`, 4, reservation-station label width.
- `clk`  in  1  rising-edge clock.
- `RST`  in  1  synchronous, active-high reset.
- `WEN`  in  1  functional unit presents a finished result this cycle.
- `dataIn`  in  DATA_W  result value.
- `labelIn`  in  LABEL_W  producing RS label.
- `isFull`  out  1  no free entry; the functional unit must hold its result.
- `require`  out  1  CDB request to CDBHelper; a valid head is present.
- `requireAC`  in  1  grant from CDBHelper.
- `dataOut`  out  DATA_W  head value, driven to the CDB mux.
- `labelOut`  out  LABEL_W  head label, driven to the CDB mux.
- `count`  out  $clog2(DEPTH+1)  occupied entries.
- `overflow`  out  1  sticky: a push was lost while full.

## Operation
- The buffer is a circular FIFO with read pointer, write pointer and occupancy counter. Pointers wrap modulo DEPTH.
- Push: `WEN && labelIn != 0 && !isFull` writes {dataIn, labelIn} at the write pointer, advances it and increments `count`.
- Label 0 (`NO_LABEL`) means "value already in register file". A push with label 0 is dropped silently and does not set `overflow`.
- Push while full: dropped and `overflow` set; `overflow` stays set until reset. No simultaneous-pop exemption applies; `isFull` is authoritative.
- `require` = (`count` != 0). `dataOut`/`labelOut` show the head entry whenever `require` = 1. They are 0 when empty.
- Pop: `require && requireAC` advances the read pointer and decrements `count`. `requireAC` while `require` = 0 is ignored.
- Push and pop in the same cycle (not full): `count` is unchanged and both pointers advance. The pushed entry is visible no earlier than the next cycle (no bypass unless configured).
- Ordering: results leave in completion order. One broadcast per grant.

## Timing
- Reset values: `count` = 0, both pointers = 0, `require` = 0, `isFull` = 0, `dataOut` = 0, `labelOut` = 0, `overflow` = 0. Storage contents are don't-care.
- `RST` asserted mid-operation flushes all entries on that edge. A grant in the same cycle is ignored and nothing is popped twice.
- Push-to-`require` latency: 1 cycle, because the entry is registered.
- Grant-to-next-head latency: the next entry appears on `dataOut` in the cycle after the grant edge.
- `isFull` is a registered-state decode (`count` == DEPTH). It deasserts the cycle after a pop from full.
- `require`, `dataOut` and `labelOut` decode from registered state only; with bypass disabled there is no combinational path from `WEN`/`dataIn` to the outputs.
- Sustained throughput: one push and one pop per cycle.

## Configuration
- `CDB_WB_BYPASS_EN` defined: when `count` == 0 and a valid push arrives, `require` asserts in the same cycle with `dataOut`/`labelOut` = `dataIn`/`labelIn` combinationally.
  - If `requireAC` is also high that cycle, the entry is consumed and not stored.
  - Otherwise it is stored as normal.
- `CDB_WB_BYPASS_EN` undefined: strict 1-cycle registered latency as described above.

## Structure
- `DATA_W`, `LABEL_W` and `NO_LABEL` (= 0) belong in the shared `head.v` constants, alongside the existing opcode macros.
- One sub-module: `wb_fifo_mem`, a DEPTH x (DATA_W+LABEL_W) register array with synchronous write and asynchronous read.
- Pointer, counter, overflow and bypass logic live in `cdb_wb_buffer`.

## Test plan
- Reset then idle: `require` = 0, `count` = 0, `dataOut` = 0 for 10 cycles. `requireAC` pulsed high with no effect.
- Push {0x0000_0005, label 3}, no grant for 3 cycles:
  - `require` high from cycle +1, `labelOut` = 3 held steady.
  - Grant at cycle +4 gives `count` = 0 and `require` = 0 next cycle.
- Push 5 results (labels 1..5) with `requireAC` low, DEPTH = 4:
  - `isFull` asserts after the 4th push, the 5th is dropped, `overflow` = 1.
  - Grants then drain labels 1, 2, 3, 4 in order.
- Simultaneous push and grant every cycle for 20 cycles: `count` stays 1, and labels on `labelOut` match the push sequence delayed by one cycle.
- Push with `labelIn` = 0: `count` unchanged and `overflow` stays 0. Assert `RST` while holding 3 entries with a grant pending: all outputs return to reset values next cycle.
- With `CDB_WB_BYPASS_EN`, empty buffer: push {0xDEAD_BEEF, label 7} with `requireAC` = 1 in the same cycle gives `labelOut` = 7 that cycle, and `count` = 0 afterwards.
